// File: rtl/flash_cmd_sequencer.sv
// Single-command sequencer for the on-chip flash IP: read, program and page erase
// over the data/CSR Avalon-MM ports with unlock, status polling, re-lock and a result pulse.
module flash_cmd_sequencer #(
   parameter logic [4:0]  WP_UNLOCK = 5'b00000,
   parameter int unsigned TIMEOUT   = 2**20,
   parameter int unsigned TO_W      = 21
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [16:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [16:0] avmm_data_addr,
   output logic        avmm_data_read,
   output logic        avmm_data_write,
   output logic [31:0] avmm_data_writedata,
   output logic [2:0]  avmm_data_burstcount,
   input  logic [31:0] avmm_data_readdata,
   input  logic        avmm_data_waitrequest,
   input  logic        avmm_data_readdatavalid,
   output logic        avmm_csr_addr,
   output logic        avmm_csr_read,
   output logic        avmm_csr_write,
   output logic [31:0] avmm_csr_writedata,
   input  logic [31:0] avmm_csr_readdata
);
   localparam int unsigned AW = 17;
   localparam int unsigned DW = 32;
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_PROG  = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;
   localparam logic [DW-1:0] LOCK_WORD   = 32'hFFFF_FFFF;
   localparam logic [DW-1:0] UNLOCK_WORD = {4'hF, WP_UNLOCK, 3'b111, 20'hFFFFF};
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_DECODE, S_RD_REQ, S_RD_WAIT, S_UNLOCK, S_WR_REQ,
      S_ERASE, S_POLL_RD, S_POLL_CHK, S_LOCK, S_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   res_data_q, res_data_d;
   logic            res_err_q, res_err_d;
   logic            busy_seen_q, busy_seen_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;
   logic [AW-1:0]   data_addr_q, data_addr_d;
   logic            data_read_q, data_read_d;
   logic            data_write_q, data_write_d;
   logic [DW-1:0]   data_wdata_q, data_wdata_d;
   logic            csr_addr_q, csr_addr_d;
   logic            csr_read_q, csr_read_d;
   logic            csr_write_q, csr_write_d;
   logic [DW-1:0]   csr_wdata_q, csr_wdata_d;
   logic            poll_done;

   logic [1:0] st_busy;
   logic       st_write_ok;
   logic       st_erase_ok;
   logic       unused_csr_bits;
   assign st_busy         = avmm_csr_readdata[1:0];
   assign st_write_ok     = avmm_csr_readdata[3];
   assign st_erase_ok     = avmm_csr_readdata[4];
   assign unused_csr_bits = ^{avmm_csr_readdata[31:5], avmm_csr_readdata[2]};

   // State and output registers; outputs are decoded from the next state so they align with it
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         res_data_q   <= '0;
         res_err_q    <= 1'b0;
         busy_seen_q  <= 1'b0;
         to_cnt_q     <= '0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         data_addr_q  <= '0;
         data_read_q  <= 1'b0;
         data_write_q <= 1'b0;
         data_wdata_q <= '0;
         csr_addr_q   <= 1'b0;
         csr_read_q   <= 1'b0;
         csr_write_q  <= 1'b0;
         csr_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
         busy_seen_q  <= busy_seen_d;
         to_cnt_q     <= to_cnt_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         data_addr_q  <= data_addr_d;
         data_read_q  <= data_read_d;
         data_write_q <= data_write_d;
         data_wdata_q <= data_wdata_d;
         csr_addr_q   <= csr_addr_d;
         csr_read_q   <= csr_read_d;
         csr_write_q  <= csr_write_d;
         csr_wdata_q  <= csr_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      busy_seen_d = busy_seen_q;
      to_cnt_d    = to_cnt_q;
      poll_done   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d       = cmd_op;
               addr_d     = cmd_addr;
               wdata_d    = cmd_wdata;
               res_data_d = '0;
               res_err_d  = 1'b0;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            case (op_q)
               OP_READ:           state_d = S_RD_REQ;
               OP_PROG, OP_ERASE: state_d = S_UNLOCK;
               default: begin
                  res_err_d = 1'b1;
                  state_d   = S_RESP;
               end
            endcase
         end
         S_RD_REQ: begin
            if (!avmm_data_waitrequest) begin
               if (avmm_data_readdatavalid) begin
                  res_data_d = avmm_data_readdata;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (avmm_data_readdatavalid) begin
               res_data_d = avmm_data_readdata;
               state_d    = S_RESP;
            end
         end
         S_UNLOCK: state_d = (op_q == OP_PROG) ? S_WR_REQ : S_ERASE;
         S_WR_REQ: begin
            // Write already completed under waitrequest, so the busy-rise phase is skipped
            if (!avmm_data_waitrequest) begin
               to_cnt_d    = '0;
               busy_seen_d = 1'b1;
               state_d     = S_POLL_RD;
            end
         end
         S_ERASE: begin
            to_cnt_d    = '0;
            busy_seen_d = 1'b0;
            state_d     = S_POLL_RD;
         end
         S_POLL_RD: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            state_d  = S_POLL_CHK;
            if (to_cnt_q == TO_LAST) begin
               res_err_d = 1'b1;
               state_d   = S_LOCK;
            end
         end
         S_POLL_CHK: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            state_d  = S_POLL_RD;
            if (!busy_seen_q) begin
               if (st_busy != 2'b00) busy_seen_d = 1'b1;
            end else if (st_busy == 2'b00) begin
               poll_done = 1'b1;
               res_err_d = (op_q == OP_PROG) ? ~st_write_ok : ~st_erase_ok;
               state_d   = S_LOCK;
            end
            if (!poll_done && (to_cnt_q == TO_LAST)) begin
               res_err_d = 1'b1;
               state_d   = S_LOCK;
            end
         end
         S_LOCK:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cmd_ready_d  = (state_d == S_IDLE);
      rsp_valid_d  = (state_d == S_RESP);
      rsp_rdata_d  = rsp_valid_d ? res_data_d : rsp_rdata_q;
      rsp_err_d    = rsp_valid_d ? res_err_d : rsp_err_q;
      data_addr_d  = '0;
      data_read_d  = 1'b0;
      data_write_d = 1'b0;
      data_wdata_d = '0;
      csr_addr_d   = 1'b0;
      csr_read_d   = 1'b0;
      csr_write_d  = 1'b0;
      csr_wdata_d  = '0;

      case (state_d)
         S_RD_REQ: begin
            data_read_d = 1'b1;
            data_addr_d = addr_q;
         end
         S_WR_REQ: begin
            data_write_d = 1'b1;
            data_addr_d  = addr_q;
            data_wdata_d = wdata_q;
         end
         S_UNLOCK: begin
            csr_write_d = 1'b1;
            csr_addr_d  = 1'b1;
            csr_wdata_d = UNLOCK_WORD;
         end
         S_ERASE: begin
            csr_write_d = 1'b1;
            csr_addr_d  = 1'b1;
            csr_wdata_d = {4'hF, WP_UNLOCK, 3'b111, 3'b000, addr_q};
         end
         S_POLL_RD: csr_read_d = 1'b1;
         S_LOCK: begin
            csr_write_d = 1'b1;
            csr_addr_d  = 1'b1;
            csr_wdata_d = LOCK_WORD;
         end
         default: ;
      endcase
   end

   assign cmd_ready            = cmd_ready_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_rdata            = rsp_rdata_q;
   assign rsp_err              = rsp_err_q;
   assign avmm_data_addr       = data_addr_q;
   assign avmm_data_read       = data_read_q;
   assign avmm_data_write      = data_write_q;
   assign avmm_data_writedata  = data_wdata_q;
   assign avmm_data_burstcount = 3'd1;
   assign avmm_csr_addr        = csr_addr_q;
   assign avmm_csr_read        = csr_read_q;
   assign avmm_csr_write       = csr_write_q;
   assign avmm_csr_writedata   = csr_wdata_q;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: reactive flash model, vector table and response scoreboard.
`timescale 1ns/1ps
module tb_flash_cmd_sequencer;
   localparam int unsigned TO_CYC = 64;
   localparam logic [31:0] UNLOCK_EXP = 32'hF07F_FFFF;
   localparam logic [31:0] LOCK_EXP   = 32'hFFFF_FFFF;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [16:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [16:0] avmm_data_addr;
   logic        avmm_data_read;
   logic        avmm_data_write;
   logic [31:0] avmm_data_writedata;
   logic [2:0]  avmm_data_burstcount;
   logic [31:0] avmm_data_readdata;
   logic        avmm_data_waitrequest;
   logic        avmm_data_readdatavalid;
   logic        avmm_csr_addr;
   logic        avmm_csr_read;
   logic        avmm_csr_write;
   logic [31:0] avmm_csr_writedata;
   logic [31:0] avmm_csr_readdata;

   flash_cmd_sequencer #(.WP_UNLOCK(5'b00000), .TIMEOUT(TO_CYC), .TO_W(21)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
      .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
      .avmm_data_burstcount(avmm_data_burstcount), .avmm_data_readdata(avmm_data_readdata),
      .avmm_data_waitrequest(avmm_data_waitrequest),
      .avmm_data_readdatavalid(avmm_data_readdatavalid),
      .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
      .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
      .avmm_csr_readdata(avmm_csr_readdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [16:0] addr;
      logic [31:0] wdata;
      int          dwait;
      int          rlat;
      logic [31:0] rdata;
      int          pre;
      int          busy_n;
      logic [1:0]  busy_val;
      logic [31:0] fin;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_rd;
      int          exp_wr;
      int          exp_csr;
      int          lat_min;
      int          lat_max;
   } vec_t;

   typedef struct { logic [31:0] rdata; logic err; int lat_min; int lat_max; } exp_t;
   typedef struct { logic [31:0] rdata; logic err; int cyc; } obs_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t exp_q[$];
   obs_t obs_q[$];
   int   obs_rd = 0;
   logic [31:0] csr_log[$];
   int   rd_cyc = 0;
   int   wr_acc = 0;
   int   proto_err = 0;
   logic [16:0] last_daddr = '0;
   logic [31:0] last_wdata = '0;

   // Flash model configuration (written by the stimulus thread)
   int          m_dwait = 0;
   int          m_rlat = 1;
   logic [31:0] m_rdata = '0;
   int          m_pre = 0;
   int          m_busy_n = 0;
   logic [1:0]  m_busy_val = 2'b00;
   logic [31:0] m_fin = '0;
   int          m_stat_base = 0;
   // Flash model state (written by the model thread)
   int   csr_rd_tot = 0;
   logic csr_rd_prev = 1'b0;
   int   wait_cnt = 0;
   logic rd_pend = 1'b0;
   int   lat_cnt = 0;

   function automatic logic [31:0] stat_word(input int i);
      if (i < m_pre) return 32'h0;
      if (i < m_pre + m_busy_n) return {30'h0, m_busy_val};
      return m_fin;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Reactive flash: answers the strobes the DUT presents in the current cycle
   initial begin
      avmm_data_waitrequest   = 1'b0;
      avmm_data_readdatavalid = 1'b0;
      avmm_data_readdata      = '0;
      avmm_csr_readdata       = '0;
      forever begin
         @(posedge clock);
         #1;
         if (csr_rd_prev) avmm_csr_readdata = stat_word(csr_rd_tot - 1 - m_stat_base);
         csr_rd_prev = avmm_csr_read;
         if (avmm_csr_read) csr_rd_tot++;
         avmm_data_readdatavalid = 1'b0;
         if (rd_pend) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
               avmm_data_readdatavalid = 1'b1;
               avmm_data_readdata      = m_rdata;
               rd_pend = 1'b0;
            end
         end
         if (avmm_data_read || avmm_data_write) begin
            if (wait_cnt < m_dwait) begin
               avmm_data_waitrequest = 1'b1;
               wait_cnt++;
            end else begin
               avmm_data_waitrequest = 1'b0;
               wait_cnt = 0;
               if (avmm_data_read) begin
                  rd_pend = 1'b1;
                  lat_cnt = m_rlat;
               end
            end
         end else begin
            avmm_data_waitrequest = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Bus monitor: logs transactions and responses, counts protocol violations
   always @(negedge clock) begin
      if (int'(avmm_data_read) + int'(avmm_data_write) + int'(avmm_csr_read) + int'(avmm_csr_write) > 1)
         proto_err++;
      if (avmm_csr_write && !avmm_csr_addr) proto_err++;
      if (avmm_csr_read && avmm_csr_addr) proto_err++;
      if (avmm_data_read) begin
         rd_cyc++;
         last_daddr = avmm_data_addr;
      end
      if (avmm_data_write && !avmm_data_waitrequest) begin
         wr_acc++;
         last_daddr = avmm_data_addr;
         last_wdata = avmm_data_writedata;
      end
      if (avmm_csr_write) csr_log.push_back(avmm_csr_writedata);
      if (rsp_valid) obs_q.push_back('{rsp_rdata, rsp_err, cyc});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %0s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #2;
   endtask

   task automatic send(input logic [1:0] op, input logic [16:0] addr, input logic [31:0] wdata,
                       output int acc);
      int waited = 0;
      while (!cmd_ready && waited < 200) begin
         step();
         waited++;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      acc       = cyc;
      step();
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      chk("ready_low_after_accept", 32'(cmd_ready), 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int acc, rd0, wr0, csr0, waited, lat;
      exp_t e;
      obs_t o;
      m_dwait = v.dwait;  m_rlat = v.rlat;  m_rdata = v.rdata;
      m_pre = v.pre;  m_busy_n = v.busy_n;  m_busy_val = v.busy_val;  m_fin = v.fin;
      m_stat_base = csr_rd_tot;
      rd0 = rd_cyc;  wr0 = wr_acc;  csr0 = csr_log.size();
      exp_q.push_back('{v.exp_rdata, v.exp_err, v.lat_min, v.lat_max});
      send(v.op, v.addr, v.wdata, acc);
      waited = 0;
      while ((obs_q.size() - obs_rd) == 0 && waited < 500) begin
         step();
         waited++;
      end
      chk($sformatf("v%0d_rsp_seen", idx), 32'(obs_q.size() - obs_rd), 32'd1);
      e = exp_q.pop_front();
      if (obs_q.size() > obs_rd) begin
         o = obs_q[obs_rd];
         obs_rd++;
         chk($sformatf("v%0d_rdata", idx), o.rdata, e.rdata);
         chk($sformatf("v%0d_err", idx), 32'(o.err), 32'(e.err));
         if (e.lat_max > 0) begin
            lat = o.cyc - acc;
            chk($sformatf("v%0d_latency_%0d_in_range", idx, lat),
                32'((lat >= e.lat_min) && (lat <= e.lat_max)), 32'd1);
         end
      end
      repeat (3) step();
      chk($sformatf("v%0d_single_rsp", idx), 32'(obs_q.size() - obs_rd), 32'd0);
      chk($sformatf("v%0d_ready_back", idx), 32'(cmd_ready), 32'd1);
      chk($sformatf("v%0d_rd_strobe_cycles", idx), 32'(rd_cyc - rd0), 32'(v.exp_rd));
      chk($sformatf("v%0d_data_writes", idx), 32'(wr_acc - wr0), 32'(v.exp_wr));
      chk($sformatf("v%0d_csr_writes", idx), 32'(csr_log.size() - csr0), 32'(v.exp_csr));
      if ((csr_log.size() - csr0) == v.exp_csr && v.exp_csr > 0) begin
         chk($sformatf("v%0d_unlock_word", idx), csr_log[csr0], UNLOCK_EXP);
         chk($sformatf("v%0d_lock_word", idx), csr_log[csr0 + v.exp_csr - 1], LOCK_EXP);
         if (v.exp_csr == 3)
            chk($sformatf("v%0d_erase_word", idx), csr_log[csr0 + 1], {12'hF07, 3'b000, v.addr});
      end
      if (v.exp_rd > 0 || v.exp_wr > 0)
         chk($sformatf("v%0d_data_addr", idx), 32'(last_daddr), 32'(v.addr));
      if (v.exp_wr > 0)
         chk($sformatf("v%0d_data_wdata", idx), last_wdata, v.wdata);
   endtask

   vec_t vecs[10];

   initial begin
      int acc, waited, csr0;
      //        op     addr       wdata         dw rl rdata         pre  busy_n   bv     fin          exp_rdata     err  rd wr csr lmin lmax
      vecs[0] = '{2'b00, 17'h00010, 32'h0,        2, 3, 32'hDEADBEEF, 0, 0,       2'b00, 32'h0,       32'hDEADBEEF, 1'b0, 3, 0, 0, 0,  0};
      vecs[1] = '{2'b01, 17'h00004, 32'h12345678, 1, 1, 32'h0,        0, 5,       2'b10, 32'h8,       32'h0,        1'b0, 0, 1, 2, 0,  0};
      vecs[2] = '{2'b10, 17'h00100, 32'h0,        0, 1, 32'h0,        1, 4,       2'b01, 32'h10,      32'h0,        1'b0, 0, 0, 3, 0,  0};
      vecs[3] = '{2'b10, 17'h1ABCD, 32'h0,        0, 1, 32'h0,        0, 1000000, 2'b01, 32'h10,      32'h0,        1'b1, 0, 0, 3, 64, 74};
      vecs[4] = '{2'b11, 17'h00155, 32'hFFFFFFFF, 0, 1, 32'h0,        0, 0,       2'b00, 32'h0,       32'h0,        1'b1, 0, 0, 0, 2,  2};
      vecs[5] = '{2'b01, 17'h1FFFF, 32'hA5A55A5A, 0, 1, 32'h0,        0, 2,       2'b11, 32'h0,       32'h0,        1'b1, 0, 1, 2, 0,  0};
      vecs[6] = '{2'b01, 17'h00ABC, 32'h0F0F1234, 3, 1, 32'h0,        0, 0,       2'b00, 32'h8,       32'h0,        1'b0, 0, 1, 2, 0,  0};
      vecs[7] = '{2'b10, 17'h00007, 32'h0,        0, 1, 32'h0,        0, 2,       2'b10, 32'h8,       32'h0,        1'b1, 0, 0, 3, 0,  0};
      vecs[8] = '{2'b00, 17'h1FFFF, 32'h0,        0, 1, 32'h01234567, 0, 0,       2'b00, 32'h0,       32'h01234567, 1'b0, 1, 0, 0, 0,  0};
      vecs[9] = '{2'b10, 17'h00020, 32'h0,        0, 1, 32'h0,        1000000, 0, 2'b00, 32'h10,      32'h0,        1'b1, 0, 0, 3, 64, 74};

      // Reset values
      repeat (3) @(posedge clock);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_strobes", {28'h0, avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write}, 32'h0);
      chk("rst_data_addr", 32'(avmm_data_addr), 32'h0);
      chk("rst_csr_wdata", avmm_csr_writedata, 32'h0);
      chk("rst_burstcount", 32'(avmm_data_burstcount), 32'd1);
      step();
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset in the middle of status polling: no response, no re-lock
      m_pre = 0;  m_busy_n = 1000000;  m_busy_val = 2'b01;  m_stat_base = csr_rd_tot;
      send(2'b10, 17'h00042, 32'h0, acc);
      waited = 0;
      while (!avmm_csr_read && waited < 50) begin
         step();
         waited++;
      end
      chk("mid_poll_reached", 32'(avmm_csr_read), 32'd1);
      csr0 = csr_log.size();
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_strobes", {28'h0, avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write}, 32'h0);
      chk("mid_rst_csr_wdata", avmm_csr_writedata, 32'h0);
      chk("mid_rst_burstcount", 32'(avmm_data_burstcount), 32'd1);
      step();
      reset_n = 1'b1;
      repeat (6) step();
      chk("mid_rst_no_rsp", 32'(obs_q.size() - obs_rd), 32'd0);
      chk("mid_rst_no_lock", 32'(csr_log.size() - csr0), 32'd0);
      run_vec(vecs[0], 10);

      chk("strobe_protocol", 32'(proto_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
Sequences the on-chip flash IP through its data and CSR Avalon-MM ports. A single-command upstream interface accepts three operations: word read, word program and page erase. The block performs write-protect unlock, the data-port transfer or erase trigger, status polling, re-lock and result reporting. It sits between the soft-CPU or loader logic and the flash macro, and it is the only master of both flash ports.

Parameters:
WP_UNLOCK, 5'b00000, write-protect field written to the control register during program/erase (1 = sector protected)
TIMEOUT, 2**20, maximum status-poll cycles before aborting with error
TO_W, 21, timeout counter width; must hold TIMEOUT

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_op  in  2  00 read, 01 program, 10 page erase, 11 reserved (error response)
cmd_addr  in  17  word address (read/program) or page address (erase)
cmd_wdata  in  32  program data
rsp_valid  out  1  one-cycle result pulse
rsp_rdata  out  32  read data (0 for non-read ops)
rsp_err  out  1  operation failed or timed out
avmm_data_addr  out  17  flash data address
avmm_data_read  out  1  data read strobe
avmm_data_write  out  1  data write strobe
avmm_data_writedata  out  32  data write word
avmm_data_burstcount  out  3  fixed 3'd1
avmm_data_readdata  in  32  data read word
avmm_data_waitrequest  in  1  data port stall
avmm_data_readdatavalid  in  1  read data valid
avmm_csr_addr  out  1  0 status, 1 control
avmm_csr_read  out  1  CSR read strobe
avmm_csr_write  out  1  CSR write strobe
avmm_csr_writedata  out  32  CSR write word
avmm_csr_readdata  in  32  CSR read data, valid the cycle after avmm_csr_read (fixed latency 1)

Behaviour:
- Reset: FSM→IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; all strobes 0; addrs/writedata 0; burstcount=1. Reset mid-operation abandons the command with no response and no re-lock; the upstream logic re-issues after reset.
- Command capture: in IDLE, cmd_valid=1 latches op/addr/wdata; cmd_ready=0 from the next cycle until rsp_valid has been issued.
- Control word: {4'hF, wp[4:0], sect[2:0], page[19:0]}. Lock word = 32'hFFFF_FFFF.
- Status fields: busy = [1:0] (00 idle), write_ok = [3], erase_ok = [4].
- Read: RD_REQ asserts avmm_data_read with addr, held while waitrequest=1 and dropped the cycle after waitrequest=0. RD_WAIT waits for readdatavalid, captures readdata, then goes to RESP with err=0. No timeout on read.
- Program: UNLOCK writes CSR addr1 with {4'hF, WP_UNLOCK, 3'b111, 20'hFFFFF} (one cycle). WR_REQ asserts avmm_data_write, held while waitrequest=1. Then POLL.
- Erase: UNLOCK as above. ERASE writes CSR addr1 with {4'hF, WP_UNLOCK, 3'b111, 3'b000, cmd_addr}. Then POLL.
- POLL: alternates a CSR addr0 read with a check cycle.
  - Phase A: wait until busy≠00 is observed. Skipped for program, because the data write has already completed under waitrequest.
  - Phase B: wait until busy==00.
  - Result: err = !write_ok (program) or !erase_ok (erase), from the final status sample.
- Timeout counter clears on POLL entry and increments every cycle in POLL. Reaching TIMEOUT sets err=1 and leaves POLL.
- LOCK: single CSR addr1 write of the lock word, always performed after program/erase, including on error or timeout. Then RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err hold until the next RESP. Returns to IDLE with cmd_ready=1 the following cycle.
- op 11: goes directly to RESP with err=1; no flash access.
- Only one strobe (data read, data write, CSR read, CSR write) is ever active in a cycle.
- Never more than one outstanding data read.

Test Plan:
- Read addr 17'h00010, model returns 32'hDEADBEEF after 2 waitrequest and 3 latency cycles → one rsp_valid, rsp_rdata=32'hDEADBEEF, err=0; avmm_data_read high exactly 3 cycles.
- Program addr 17'h00004 data 32'h12345678, status busy=10 for 5 polls then 00 with bit3=1 → CSR writes in order 32'hF07FFFFF, then 32'hFFFFFFFF; data write seen once; err=0.
- Erase page 17'h00100, status busy 00,01×4,00 with bit4=1 → control write 32'hF0700100, lock write follows, err=0.
- Erase with busy stuck at 01, TIMEOUT=64 → rsp_err=1 within 64 + a few cycles, lock word still written.
- cmd_op=11 → rsp_valid with err=1 two cycles after acceptance, no avmm strobes.
- reset_n low for one cycle during POLL → all outputs at reset values next cycle, cmd_ready=1, no rsp_valid; a following read completes normally.
